// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the CPU memory bus. It services MREAD/MWRITE
//   commands against a word RAM (lower half of the address space) and a small
//   block of memory-mapped I/O (upper half): LED register, synchronised
//   switches and a free-running compare timer. It also flags any mem_cmd
//   that is not one-hot.
//
// Ports
//   clk       in   1       rising-edge clock
//   reset     in   1       asynchronous, active-low reset
//   mem_cmd   in   3       one-hot command: 001 none, 010 read, 100 write
//   mem_addr  in   ADDR_W  word address from the CPU
//   din       in   DATA_W  write data from the CPU datapath
//   dout      out  DATA_W  registered read data (one cycle latency)
//   sw        in   SW_W    asynchronous board switches
//   led       out  SW_W    LED register
//   tmr_hit   out  1       sticky timer compare flag
//   cmd_err   out  1       sticky illegal-command flag
//
// Address map (upper half, mem_addr[ADDR_W-1]==1)
//   0x100 LED (R/W), 0x140 SW (RO), 0x180 TCOUNT (R/W), 0x181 TCMP (R/W),
//   0x182 TCTRL (bit0 enable R/W, bit1 write-one-to-clear tmr_hit, reads 0).
//   Every other upper-half address reads 0 and ignores writes.
//
// RAM contents are not reset. Writes to RAM are qualified only by the
// command, so the CPU is expected to present MNONE while it is in reset.
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9,
    parameter int SW_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    input  logic [SW_W-1:0]   sw,
    output logic [SW_W-1:0]   led,
    output logic              tmr_hit,
    output logic              cmd_err
);

    localparam logic [2:0] CMD_NONE  = 3'b001;
    localparam logic [2:0] CMD_READ  = 3'b010;
    localparam logic [2:0] CMD_WRITE = 3'b100;

    localparam logic [ADDR_W-1:0] ADDR_LED    = 9'h100;
    localparam logic [ADDR_W-1:0] ADDR_SW     = 9'h140;
    localparam logic [ADDR_W-1:0] ADDR_TCOUNT = 9'h180;
    localparam logic [ADDR_W-1:0] ADDR_TCMP   = 9'h181;
    localparam logic [ADDR_W-1:0] ADDR_TCTRL  = 9'h182;

    localparam int RAM_DEPTH = 2 ** (ADDR_W - 1);

    // Legal commands are exactly the three one-hot encodings.
    function automatic logic cmd_is_legal(input logic [2:0] cmd);
        case (cmd)
            CMD_NONE, CMD_READ, CMD_WRITE: cmd_is_legal = 1'b1;
            default:                       cmd_is_legal = 1'b0;
        endcase
    endfunction

    logic [DATA_W-1:0] ram_r [0:RAM_DEPTH-1];

    logic [DATA_W-1:0] dout_r;
    logic [SW_W-1:0]   led_r;
    logic [SW_W-1:0]   sw_meta_r;
    logic [SW_W-1:0]   sw_sync_r;
    logic [DATA_W-1:0] tcount_r;
    logic [DATA_W-1:0] tcmp_r;
    logic              ten_r;
    logic              tmr_hit_r;
    logic              cmd_err_r;

    logic              is_read_s;
    logic              is_write_s;
    logic              is_illegal_s;
    logic              ram_sel_s;
    logic              led_sel_s;
    logic              tcount_sel_s;
    logic              tcmp_sel_s;
    logic              tctrl_sel_s;
    logic [DATA_W-1:0] rd_data_s;
    logic [DATA_W-1:0] tcount_nxt_s;
    logic              tmr_set_s;
    logic              tmr_clr_s;
    logic              tmr_hit_nxt_s;

    // Command and address decode.
    always_comb begin
        is_read_s    = (mem_cmd == CMD_READ);
        is_write_s   = (mem_cmd == CMD_WRITE);
        is_illegal_s = !cmd_is_legal(mem_cmd);
        ram_sel_s    = !mem_addr[ADDR_W-1];
        led_sel_s    = (mem_addr == ADDR_LED);
        tcount_sel_s = (mem_addr == ADDR_TCOUNT);
        tcmp_sel_s   = (mem_addr == ADDR_TCMP);
        tctrl_sel_s  = (mem_addr == ADDR_TCTRL);
    end

    // Read mux: returns the current (pre-edge) value of the addressed word.
    always_comb begin
        rd_data_s = {DATA_W{1'b0}};
        if (ram_sel_s) begin
            rd_data_s = ram_r[mem_addr[ADDR_W-2:0]];
        end else begin
            case (mem_addr)
                ADDR_LED:    rd_data_s = {{(DATA_W-SW_W){1'b0}}, led_r};
                ADDR_SW:     rd_data_s = {{(DATA_W-SW_W){1'b0}}, sw_sync_r};
                ADDR_TCOUNT: rd_data_s = tcount_r;
                ADDR_TCMP:   rd_data_s = tcmp_r;
                ADDR_TCTRL:  rd_data_s = {{(DATA_W-1){1'b0}}, ten_r};
                default:     rd_data_s = {DATA_W{1'b0}};
            endcase
        end
    end

    // Timer next state: a CPU write to TCOUNT beats the increment, and a
    // write-one-to-clear of tmr_hit beats a compare match in the same cycle.
    always_comb begin
        tcount_nxt_s = tcount_r;
        if (is_write_s && tcount_sel_s) begin
            tcount_nxt_s = din;
        end else if (ten_r) begin
            tcount_nxt_s = tcount_r + {{(DATA_W-1){1'b0}}, 1'b1};
        end else begin
            tcount_nxt_s = tcount_r;
        end

        tmr_set_s = ten_r && (tcount_r == tcmp_r);
        tmr_clr_s = is_write_s && tctrl_sel_s && din[1];

        tmr_hit_nxt_s = tmr_hit_r;
        if (tmr_clr_s) begin
            tmr_hit_nxt_s = 1'b0;
        end else if (tmr_set_s) begin
            tmr_hit_nxt_s = 1'b1;
        end else begin
            tmr_hit_nxt_s = tmr_hit_r;
        end
    end

    // Control/status registers, read-data register and sticky flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_r    <= {DATA_W{1'b0}};
            led_r     <= {SW_W{1'b0}};
            tcount_r  <= {DATA_W{1'b0}};
            tcmp_r    <= {DATA_W{1'b0}};
            ten_r     <= 1'b0;
            tmr_hit_r <= 1'b0;
            cmd_err_r <= 1'b0;
        end else begin
            if (is_read_s) begin
                dout_r <= rd_data_s;
            end
            if (is_write_s && led_sel_s) begin
                led_r <= din[SW_W-1:0];
            end
            if (is_write_s && tcmp_sel_s) begin
                tcmp_r <= din;
            end
            if (is_write_s && tctrl_sel_s) begin
                ten_r <= din[0];
            end
            tcount_r  <= tcount_nxt_s;
            tmr_hit_r <= tmr_hit_nxt_s;
            cmd_err_r <= cmd_err_r | is_illegal_s;
        end
    end

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta_r <= {SW_W{1'b0}};
            sw_sync_r <= {SW_W{1'b0}};
        end else begin
            sw_meta_r <= sw;
            sw_sync_r <= sw_meta_r;
        end
    end

    // Data RAM write port (no reset on the storage array).
    always_ff @(posedge clk) begin
        if (is_write_s && ram_sel_s) begin
            ram_r[mem_addr[ADDR_W-2:0]] <= din;
        end
    end

    assign dout    = dout_r;
    assign led     = led_r;
    assign tmr_hit = tmr_hit_r;
    assign cmd_err = cmd_err_r;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//   Self-checking bench for mem_responder. A behavioural model of the memory
//   map (RAM array, LED, switch pipeline, timer, sticky flags) is advanced
//   once per clock from the applied command, and every cycle the DUT outputs
//   are compared with it. Directed sequences pin the model with literal
//   expectations; a randomized phase then exercises the whole map.
// ---------------------------------------------------------------------------
module tb_mem_responder;

    localparam logic [2:0] MNONE  = 3'b001;
    localparam logic [2:0] MREAD  = 3'b010;
    localparam logic [2:0] MWRITE = 3'b100;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic [7:0]  sw;
    logic [7:0]  led;
    logic        tmr_hit;
    logic        cmd_err;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [15:0] ram_m [0:255];
    logic [15:0] dout_m;
    logic [7:0]  led_m;
    logic [7:0]  meta_m;
    logic [7:0]  sync_m;
    logic [15:0] cnt_m;
    logic [15:0] cmp_m;
    logic        ten_m;
    logic        hit_m;
    logic        err_m;
    logic [7:0]  sw_v = 8'h00;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk      (clk),
        .reset    (reset),
        .mem_cmd  (mem_cmd),
        .mem_addr (mem_addr),
        .din      (din),
        .dout     (dout),
        .sw       (sw),
        .led      (led),
        .tmr_hit  (tmr_hit),
        .cmd_err  (cmd_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("dout", {16'h0, dout}, {16'h0, dout_m});
        chk("led", {24'h0, led}, {24'h0, led_m});
        chk("tmr_hit", {31'h0, tmr_hit}, {31'h0, hit_m});
        chk("cmd_err", {31'h0, cmd_err}, {31'h0, err_m});
    endtask

    task automatic model_reset();
        dout_m = 16'h0000; led_m = 8'h00; meta_m = 8'h00; sync_m = 8'h00;
        cnt_m  = 16'h0000; cmp_m = 16'h0000;
        ten_m  = 1'b0; hit_m = 1'b0; err_m = 1'b0;
    endtask

    function automatic logic [15:0] model_read(input logic [8:0] a);
        if (a < 9'h100) return ram_m[a[7:0]];
        case (a)
            9'h100:  return {8'h00, led_m};
            9'h140:  return {8'h00, sync_m};
            9'h180:  return cnt_m;
            9'h181:  return cmp_m;
            9'h182:  return {15'h0000, ten_m};
            default: return 16'h0000;
        endcase
    endfunction

    // One bus cycle: drive at negedge, advance the model at posedge, compare.
    task automatic step(input logic [2:0] c, input logic [8:0] a, input logic [15:0] d);
        logic        rd, wr, legal;
        logic [15:0] n_dout, n_cnt, n_cmp;
        logic [7:0]  n_led;
        logic        n_ten, n_hit, n_err;
        @(negedge clk);
        mem_cmd = c; mem_addr = a; din = d; sw = sw_v;
        rd    = (c == MREAD);
        wr    = (c == MWRITE);
        legal = (c == MNONE) || rd || wr;
        n_dout = rd ? model_read(a) : dout_m;
        n_led  = (wr && a == 9'h100) ? d[7:0] : led_m;
        n_cmp  = (wr && a == 9'h181) ? d : cmp_m;
        n_ten  = (wr && a == 9'h182) ? d[0] : ten_m;
        if (wr && a == 9'h180)  n_cnt = d;
        else if (ten_m)         n_cnt = cnt_m + 16'd1;
        else                    n_cnt = cnt_m;
        if (wr && a == 9'h182 && d[1])      n_hit = 1'b0;
        else if (ten_m && cnt_m == cmp_m)   n_hit = 1'b1;
        else                                n_hit = hit_m;
        n_err = err_m || !legal;
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            if (wr && a < 9'h100) ram_m[a[7:0]] = d;
            dout_m = n_dout; led_m = n_led; cmp_m = n_cmp; ten_m = n_ten;
            cnt_m = n_cnt; hit_m = n_hit; err_m = n_err;
            sync_m = meta_m; meta_m = sw_v;
        end
        #1;
        compare_all();
    endtask

    // Asynchronous reset pulse asserted between edges; dout must clear at once.
    task automatic do_reset();
        mem_cmd = MNONE;
        reset = 1'b0;
        #1;
        model_reset();
        chk("reset_async_dout", {16'h0, dout}, 32'h0000_0000);
        compare_all();
        step(MNONE, 9'h000, 16'h0000);
        step(MNONE, 9'h000, 16'h0000);
        reset = 1'b1;
    endtask

    initial begin
        int hit_edge;
        logic [2:0] c;
        logic [8:0] a;
        logic [15:0] d;
        int r;

        reset = 1'b1; mem_cmd = MNONE; mem_addr = 9'h000; din = 16'h0000; sw = 8'h00;
        #2;
        do_reset();

        // Preload the whole RAM so every later read has a known value.
        for (int i = 0; i < 256; i++) begin
            d = (i == 0) ? 16'hD105 : 16'($urandom);
            step(MWRITE, 9'(i), d);
        end

        // 1: read after reset, then asynchronous reset during hold.
        do_reset();
        step(MREAD, 9'h000, 16'h0000);
        chk("t1_read0", {16'h0, dout}, 32'h0000_D105);
        step(MNONE, 9'h000, 16'h0000);
        chk("t1_hold", {16'h0, dout}, 32'h0000_D105);
        do_reset();

        // 2: write then read back next cycle; MNONE holds dout.
        step(MWRITE, 9'h00A, 16'h1234);
        step(MREAD, 9'h00A, 16'h0000);
        chk("t2_read", {16'h0, dout}, 32'h0000_1234);
        step(MNONE, 9'h055, 16'hBEEF);
        step(MNONE, 9'h000, 16'h0000);
        chk("t2_hold", {16'h0, dout}, 32'h0000_1234);

        // 3: LED write/read and switch synchroniser.
        step(MWRITE, 9'h100, 16'h00A5);
        chk("t3_led", {24'h0, led}, 32'h0000_00A5);
        step(MREAD, 9'h100, 16'h0000);
        chk("t3_led_rd", {16'h0, dout}, 32'h0000_00A5);
        sw_v = 8'h3C;
        step(MNONE, 9'h000, 16'h0000);
        step(MNONE, 9'h000, 16'h0000);
        step(MREAD, 9'h140, 16'h0000);
        chk("t3_sw_rd", {16'h0, dout}, 32'h0000_003C);

        // 4: timer compare, clear, wrap and clear-beats-set.
        step(MWRITE, 9'h181, 16'h0005);
        step(MWRITE, 9'h182, 16'h0001);
        hit_edge = 0;
        for (int k = 1; k <= 20; k++) begin
            step(MNONE, 9'h000, 16'h0000);
            if (tmr_hit && hit_edge == 0) hit_edge = k;
        end
        chk("t4_hit_edge", 32'(hit_edge), 32'd6);
        step(MWRITE, 9'h182, 16'h0002);
        chk("t4_clear", {31'h0, tmr_hit}, 32'h0);
        step(MWRITE, 9'h182, 16'h0001);
        step(MWRITE, 9'h180, 16'hFFFF);
        step(MNONE, 9'h000, 16'h0000);
        step(MREAD, 9'h180, 16'h0000);
        chk("t4_wrap", {16'h0, dout}, 32'h0000_0000);
        step(MWRITE, 9'h180, 16'h0004);
        step(MNONE, 9'h000, 16'h0000);
        step(MWRITE, 9'h182, 16'h0003);
        chk("t4_clr_wins", {31'h0, tmr_hit}, 32'h0);
        step(MWRITE, 9'h182, 16'h0000);

        // 5: illegal command performs nothing but sets cmd_err.
        step(MREAD, 9'h00A, 16'h0000);
        step(3'b110, 9'h00A, 16'hFFFF);
        chk("t5_err", {31'h0, cmd_err}, 32'h1);
        chk("t5_dout", {16'h0, dout}, 32'h0000_1234);
        step(MREAD, 9'h00A, 16'h0000);
        chk("t5_ram", {16'h0, dout}, 32'h0000_1234);

        // 6: unmapped I/O address.
        step(MREAD, 9'h1F0, 16'h0000);
        chk("t6_rd", {16'h0, dout}, 32'h0000_0000);
        step(MWRITE, 9'h1F0, 16'hFFFF);
        step(MREAD, 9'h100, 16'h0000);
        chk("t6_led", {16'h0, dout}, 32'h0000_00A5);

        // Randomized phase against the model.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            if ($urandom_range(0, 7) == 0) sw_v = 8'($urandom);
            r = $urandom_range(0, 39);
            if (r < 15)      c = MREAD;
            else if (r < 30) c = MWRITE;
            else if (r < 39) c = MNONE;
            else             c = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0, 1:    a = {1'b0, 8'($urandom)};
                2:       a = 9'h100;
                3:       a = 9'h140;
                4:       a = 9'h180;
                5:       a = 9'h181;
                6:       a = 9'h182;
                default: a = {1'b1, 8'($urandom)};
            endcase
            d = 16'($urandom);
            if (a == 9'h180 || a == 9'h181) d = 16'($urandom_range(0, 31));
            step(c, a, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
